shift_register8_sched: RTL and testbench

Sequencer for the 8-sample complex parallel-to-serial shift register (`shift_register8_ctrl`) at a 64-point FFT stage output. It accepts 8-sample blocks from the upstream radix-8 butterfly with a valid/ready handshake and drives the register's load strobe (`ren`) and shift enable (`men`). It honours downstream back-pressure, tracks the block/sample position within a 64-sample frame, and flags frame boundaries and framing errors.

---
 rtl/shift_register8_sched_if.sv | 25 ++
 rtl/shift_register8_sched.sv | 126 ++++++++++++
 tb/tb_shift_register8_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register8_sched_if.sv
// Block/sample handshake bundle between the FFT-stage sequencer and its
// upstream butterfly / downstream serial consumer.
interface shift_register8_sched_if #(
    parameter int IDX_W = 6
);
    logic             blk_valid;
    logic             blk_last;
    logic             blk_ready;
    logic             dn_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;

    // Traffic side: offers blocks and consumes serial samples.
    modport master (
        output blk_valid, blk_last, dn_ready,
        input  blk_ready, out_valid, out_idx, out_last
    );

    // Sequencer side.
    modport slave (
        input  blk_valid, blk_last, dn_ready,
        output blk_ready, out_valid, out_idx, out_last
    );
endinterface

// File: rtl/shift_register8_sched.sv
// Sequencer for the 8-sample parallel-to-serial shift register at a 64-point
// FFT stage output: accepts blocks, drives load/shift strobes, tracks the
// block/sample position in the frame and flags framing errors.
module shift_register8_sched #(
    parameter int NSAMP = 8,
    parameter int NBLK  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    shift_register8_sched_if.slave  bus,
    input  logic                    abort,
    output logic                    ren,
    output logic                    men,
    output logic                    sync_err,
    output logic                    busy
);
    localparam int SW = $clog2(NSAMP);
    localparam int BW = $clog2(NBLK);
    localparam logic [SW-1:0] SCNT_MAX = SW'(NSAMP - 1);
    localparam logic [BW-1:0] BCNT_MAX = BW'(NBLK - 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] scnt;
    logic [BW-1:0] bcnt;
    logic          last_q;

    logic at_last_blk;
    logic blk_end;

    assign at_last_blk = (bcnt == BCNT_MAX);
    // The shift that empties the register; only meaningful while men is high.
    assign blk_end     = (scnt == SCNT_MAX);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision; abort wins over both load and shift.
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:  state_nxt = IDLE;
            IDLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bus.blk_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (bus.dn_ready && blk_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Strobes and status decoded from state and live inputs; ren and men are
    // mutually exclusive by construction since they belong to different states.
    always_comb begin
        bus.blk_ready = 1'b0;
        ren           = 1'b0;
        men           = 1'b0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                bus.blk_ready = !abort;
                ren           = bus.blk_valid && !abort;
            end
            SHIFT: begin
                busy = 1'b1;
                men  = bus.dn_ready && !abort;
            end
            default: ;
        endcase
        bus.out_valid = men;
        bus.out_last  = men && blk_end && last_q;
    end

    assign bus.out_idx = {bcnt, scnt};

    // Position counters, end-of-frame flag and the registered framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt     <= '0;
            bcnt     <= '0;
            last_q   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (abort && state != INIT) begin
                scnt   <= '0;
                bcnt   <= '0;
                last_q <= 1'b0;
            end else if (ren) begin
                scnt     <= '0;
                last_q   <= bus.blk_last || at_last_blk;
                sync_err <= bus.blk_last ^ at_last_blk;
            end else if (men) begin
                scnt <= scnt + 1'b1;
                if (blk_end) begin
                    bcnt <= last_q ? '0 : bcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_register8_sched.sv
// Self-checking bench for shift_register8_sched: directed scenarios followed by
// randomized traffic, all compared cycle by cycle with a frame-position model.
module tb_shift_register8_sched;
    localparam int NSAMP = 8;
    localparam int NBLK  = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic abort;
    logic ren;
    logic men;
    logic sync_err;
    logic busy;

    shift_register8_sched_if #(.IDX_W(6)) bus ();

    shift_register8_sched #(.NSAMP(NSAMP), .NBLK(NBLK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .abort    (abort),
        .ren      (ren),
        .men      (men),
        .sync_err (sync_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: absolute sample position within the frame, whether a
    // block is currently held, whether it closes the frame, pending error pulse.
    bit m_init;
    bit m_busy;
    int m_pos;
    bit m_frame_end;
    bit m_err;

    // Observations from the latest step, used by the directed scenarios.
    int o_ren, o_men, o_last, o_err, o_ready, o_idx;

    task automatic model_reset();
        m_init      = 1'b1;
        m_busy      = 1'b0;
        m_pos       = 0;
        m_frame_end = 1'b0;
        m_err       = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare shortly after,
    // then advance the model on the rising edge.
    task automatic step(input bit v, input bit l, input bit d, input bit a, input bit r);
        bit e_idle;
        bit e_shift;
        bit e_men;
        bit nerr;
        int blk;
        @(negedge clk);
        bus.blk_valid = v;
        bus.blk_last  = l;
        bus.dn_ready  = d;
        abort         = a;
        rst_n         = r;
        if (!r) model_reset();
        #1;
        e_idle  = !m_init && !m_busy;
        e_shift = !m_init && m_busy;
        e_men   = e_shift && d && !a;
        check("blk_ready", 32'(bus.blk_ready), 32'(e_idle && !a));
        check("ren",       32'(ren),           32'(e_idle && v && !a));
        check("men",       32'(men),           32'(e_men));
        check("out_valid", 32'(bus.out_valid), 32'(e_men));
        check("out_idx",   32'(bus.out_idx),   32'(m_pos));
        check("out_last",  32'(bus.out_last),
              32'(e_men && (m_pos % NSAMP == NSAMP - 1) && m_frame_end));
        check("sync_err",  32'(sync_err),      32'(m_err));
        check("busy",      32'(busy),          32'(e_shift));
        check("ren_men_excl", 32'(ren && men), 32'(0));
        o_ren   = int'(ren);
        o_men   = int'(men);
        o_last  = int'(bus.out_last);
        o_err   = int'(sync_err);
        o_ready = int'(bus.blk_ready);
        o_idx   = int'(bus.out_idx);
        @(posedge clk);
        if (r) begin
            nerr = 1'b0;
            if (m_init) begin
                m_init = 1'b0;
            end else if (a) begin
                m_busy      = 1'b0;
                m_pos       = 0;
                m_frame_end = 1'b0;
            end else if (!m_busy) begin
                if (v) begin
                    blk         = m_pos / NSAMP;
                    m_frame_end = l || (blk == NBLK - 1);
                    nerr        = (l != (blk == NBLK - 1));
                    m_busy      = 1'b1;
                    m_pos       = blk * NSAMP;
                end
            end else if (d) begin
                if (m_pos % NSAMP == NSAMP - 1) begin
                    m_busy = 1'b0;
                    m_pos  = m_frame_end ? 0 : m_pos + 1;
                end else begin
                    m_pos++;
                end
            end
            m_err = nerr;
        end
    endtask

    // Load one block and shift it out unstalled, checking the expected indices.
    task automatic run_block(input bit l, input int base, inout int nlast, inout int lidx,
                             inout int nerr);
        step(1'b1, l, 1'b1, 1'b0, 1'b1);
        check("blk_load_ren", 32'(o_ren), 32'(1));
        for (int s = 0; s < NSAMP; s++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            check("blk_idx", 32'(o_idx), 32'(base + s));
            if (o_last != 0) begin
                nlast++;
                lidx = o_idx;
            end
            nerr += o_err;
        end
    endtask

    initial begin
        int cnt, nlast, lidx, nerr;
        bus.blk_valid = 1'b0;
        bus.blk_last  = 1'b0;
        bus.dn_ready  = 1'b0;
        abort         = 1'b0;
        rst_n         = 1'b0;
        model_reset();

        // Reset state and a single unstalled block.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_idx", 32'(o_idx), 32'(0));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("init_ready", 32'(o_ready), 32'(0));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s1_ren", 32'(o_ren), 32'(1));
        cnt = 0;
        for (int i = 0; i < NSAMP; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            cnt += o_men;
            check("s1_idx", 32'(o_idx), 32'(i));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s1_ready_c10", 32'(o_ready), 32'(1));
        check("s1_men_cnt", 32'(cnt), 32'(NSAMP));

        // Full frame with blk_last on the eighth block.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        nlast = 0; lidx = -1; nerr = 0;
        for (int b = 0; b < NBLK; b++) run_block(b == NBLK - 1, b * NSAMP, nlast, lidx, nerr);
        check("s2_nlast", 32'(nlast), 32'(1));
        check("s2_last_idx", 32'(lidx), 32'(63));
        check("s2_no_err", 32'(nerr), 32'(0));

        // Three-cycle stall while scnt is 4.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            check("s3_stall_men", 32'(o_men), 32'(0));
            check("s3_stall_idx", 32'(o_idx), 32'(4));
        end
        for (int s = 4; s < NSAMP; s++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            check("s3_resume_idx", 32'(o_idx), 32'(s));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s3_ready_late", 32'(o_ready), 32'(1));

        // Early blk_last on block 2.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        nlast = 0; lidx = -1; nerr = 0;
        for (int b = 0; b < 2; b++) run_block(1'b0, b * NSAMP, nlast, lidx, nerr);
        check("s4_no_err_early", 32'(nerr), 32'(0));
        run_block(1'b1, 16, nlast, lidx, nerr);
        check("s4_err_once", 32'(nerr), 32'(1));
        check("s4_last_idx", 32'(lidx), 32'(23));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s4_next_idx", 32'(o_idx), 32'(0));

        // Eight blocks with no blk_last.
        nlast = 0; lidx = -1; nerr = 0;
        for (int b = 0; b < NBLK - 1; b++) run_block(1'b0, b * NSAMP, nlast, lidx, nerr);
        check("s5_no_err_early", 32'(nerr), 32'(0));
        run_block(1'b0, 56, nlast, lidx, nerr);
        check("s5_err_once", 32'(nerr), 32'(1));
        check("s5_last_idx", 32'(lidx), 32'(63));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s5_wrap_idx", 32'(o_idx), 32'(0));

        // Abort at scnt 5 of block 3.
        nlast = 0; lidx = -1; nerr = 0;
        for (int b = 0; b < 3; b++) run_block(1'b0, b * NSAMP, nlast, lidx, nerr);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("s6_abort_men", 32'(o_men), 32'(0));
        check("s6_abort_ren", 32'(o_ren), 32'(0));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s6_abort_idx", 32'(o_idx), 32'(0));
        run_block(1'b0, 0, nlast, lidx, nerr);

        // Reset at scnt 2.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 2; s++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("s6_rst_men", 32'(o_men), 32'(0));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_block(1'b0, 0, nlast, lidx, nerr);
        check("s6_no_last", 32'(nlast), 32'(0));

        // Randomized traffic with stalls, early/missing blk_last, aborts and resets.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) < 3,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 299) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
